// File: rtl/snake_head_ctrl_if.sv
// Bus between the snake head controller and its keyboard/vsync source and sprite renderer.
// The master drives keycode and frame_clk; the slave (controller) drives head state.
interface snake_head_ctrl_if;
    logic       frame_clk;
    logic [7:0] keycode;
    logic [9:0] snakeX_pos;
    logic [9:0] snakeY_pos;
    logic [9:0] snake_size;
    logic [1:0] motionFlag;
    logic [1:0] game_state;
    logic       step_pulse;
    logic       dead;

    modport master (
        output frame_clk, keycode,
        input  snakeX_pos, snakeY_pos, snake_size, motionFlag, game_state, step_pulse, dead
    );

    modport slave (
        input  frame_clk, keycode,
        output snakeX_pos, snakeY_pos, snake_size, motionFlag, game_state, step_pulse, dead
    );
endinterface

// File: rtl/snake_head_ctrl.sv
// Player-1 snake head motion controller: keycodes and frame ticks drive a committed
// direction, a grid-stepped head position and the IDLE/RUN/DEAD game sequence.
module snake_head_ctrl #(
    parameter int unsigned STEP            = 24,
    parameter int unsigned FRAMES_PER_STEP = 8,
    parameter int unsigned X_MIN           = 12,
    parameter int unsigned X_MAX           = 627,
    parameter int unsigned Y_MIN           = 12,
    parameter int unsigned Y_MAX           = 467,
    parameter int unsigned START_X         = 320,
    parameter int unsigned START_Y         = 240
) (
    input  logic              Clk,
    input  logic              Reset,
    snake_head_ctrl_if.slave  bus
);

    localparam int unsigned POS_W  = 10;
    localparam int unsigned CNT_W  = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
    localparam int unsigned HALF_SIZE = 12;

    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(FRAMES_PER_STEP - 1);
    localparam logic [POS_W-1:0] STEP_P     = POS_W'(STEP);
    localparam logic [POS_W:0]   STEP_W     = (POS_W + 1)'(STEP);
    localparam logic [POS_W:0]   X_LO_LIM   = (POS_W + 1)'(X_MIN + STEP);
    localparam logic [POS_W:0]   Y_LO_LIM   = (POS_W + 1)'(Y_MIN + STEP);
    localparam logic [POS_W:0]   X_HI_LIM   = (POS_W + 1)'(X_MAX);
    localparam logic [POS_W:0]   Y_HI_LIM   = (POS_W + 1)'(Y_MAX);
    localparam logic [POS_W-1:0] START_X_P  = POS_W'(START_X);
    localparam logic [POS_W-1:0] START_Y_P  = POS_W'(START_Y);

    localparam logic [1:0] DIR_W = 2'b00;
    localparam logic [1:0] DIR_A = 2'b01;
    localparam logic [1:0] DIR_S = 2'b10;
    localparam logic [1:0] DIR_D = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DEAD = 2'b10
    } state_e;

    state_e             state_q, state_d;
    logic               frame_q, frame_d_q;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         pend_q, pend_d;
    logic [1:0]         motion_q, motion_d;
    logic [POS_W-1:0]   x_q, x_d;
    logic [POS_W-1:0]   y_q, y_d;
    logic               step_q, step_d;
    logic               dead_q, dead_d;

    logic               tick_c;
    logic               key_dir_vld_c;
    logic [1:0]         key_dir_c;
    logic               key_enter_c;
    logic               step_now_c;
    logic               die_c;
    logic [POS_W-1:0]   cand_x_c, cand_y_c;

    // frame_clk is resampled so a rising edge seen at edge n yields a tick in cycle n+1
    assign tick_c      = frame_q & ~frame_d_q;
    assign key_enter_c = (bus.keycode == 8'h28);
    assign step_now_c  = (state_q == ST_RUN) && tick_c && (cnt_q == CNT_LAST);

    always_comb begin
        key_dir_vld_c = 1'b1;
        key_dir_c     = DIR_W;
        case (bus.keycode)
            8'h1A:   key_dir_c = DIR_W;
            8'h04:   key_dir_c = DIR_A;
            8'h16:   key_dir_c = DIR_S;
            8'h07:   key_dir_c = DIR_D;
            default: key_dir_vld_c = 1'b0;
        endcase
    end

    // Candidate position for the pending direction; bounds use widened, non-wrapping compares
    always_comb begin
        cand_x_c = x_q;
        cand_y_c = y_q;
        die_c    = 1'b0;
        case (pend_q)
            DIR_W: begin
                cand_y_c = y_q - STEP_P;
                die_c    = ({1'b0, y_q} < Y_LO_LIM);
            end
            DIR_A: begin
                cand_x_c = x_q - STEP_P;
                die_c    = ({1'b0, x_q} < X_LO_LIM);
            end
            DIR_S: begin
                cand_y_c = y_q + STEP_P;
                die_c    = (({1'b0, y_q} + STEP_W) > Y_HI_LIM);
            end
            default: begin
                cand_x_c = x_q + STEP_P;
                die_c    = (({1'b0, x_q} + STEP_W) > X_HI_LIM);
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= ST_IDLE;
            frame_q   <= 1'b0;
            frame_d_q <= 1'b0;
            cnt_q     <= '0;
            pend_q    <= DIR_W;
            motion_q  <= DIR_W;
            x_q       <= START_X_P;
            y_q       <= START_Y_P;
            step_q    <= 1'b0;
            dead_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            frame_q   <= bus.frame_clk;
            frame_d_q <= frame_q;
            cnt_q     <= cnt_d;
            pend_q    <= pend_d;
            motion_q  <= motion_d;
            x_q       <= x_d;
            y_q       <= y_d;
            step_q    <= step_d;
            dead_q    <= dead_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (key_dir_vld_c)        state_d = ST_RUN;
            ST_RUN:  if (step_now_c && die_c)  state_d = ST_DEAD;
            ST_DEAD: if (key_enter_c)          state_d = ST_IDLE;
            default:                           state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cnt_d    = cnt_q;
        pend_d   = pend_q;
        motion_d = motion_q;
        x_d      = x_q;
        y_d      = y_q;
        step_d   = 1'b0;
        dead_d   = (state_d == ST_DEAD);
        case (state_q)
            ST_IDLE: begin
                if (key_dir_vld_c) begin
                    motion_d = key_dir_c;
                    pend_d   = key_dir_c;
                    cnt_d    = '0;
                end
            end
            ST_RUN: begin
                // Reversal is judged against the direction committed before this edge
                if (key_dir_vld_c && (key_dir_c != (motion_q ^ 2'b10))) begin
                    pend_d = key_dir_c;
                end
                if (tick_c) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d = '0;
                        if (!die_c) begin
                            x_d      = cand_x_c;
                            y_d      = cand_y_c;
                            motion_d = pend_q;
                            step_d   = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_DEAD: begin
                if (key_enter_c) begin
                    x_d      = START_X_P;
                    y_d      = START_Y_P;
                    motion_d = DIR_W;
                    pend_d   = DIR_W;
                    cnt_d    = '0;
                end
            end
            default: ;
        endcase
    end

    assign bus.snakeX_pos = x_q;
    assign bus.snakeY_pos = y_q;
    assign bus.snake_size = POS_W'(HALF_SIZE);
    assign bus.motionFlag = motion_q;
    assign bus.game_state = state_q;
    assign bus.step_pulse = step_q;
    assign bus.dead       = dead_q;

endmodule

// File: tb/tb_snake_head_ctrl.sv
// Self-checking bench for snake_head_ctrl: expected step results are queued as stimulus
// is applied and popped whenever the controller reports a committed step.
module tb_snake_head_ctrl;

    typedef struct {
        logic [9:0] x;
        logic [9:0] y;
        logic [1:0] dir;
    } step_exp_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;
    int   pulse_cnt;
    logic prev_pulse;
    int   pc;
    step_exp_t sb_q[$];

    snake_head_ctrl_if bus ();

    snake_head_ctrl dut (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end else begin
            n_pass++;
        end
    endtask

    task automatic push_exp(input int x, input int y, input int dir);
        step_exp_t e;
        e.x   = 10'(x);
        e.y   = 10'(y);
        e.dir = 2'(dir);
        sb_q.push_back(e);
    endtask

    task automatic press(input logic [7:0] k);
        bus.keycode = k;
        @(negedge clk);
        bus.keycode = 8'h00;
    endtask

    task automatic do_frames(input int n);
        for (int i = 0; i < n; i++) begin
            bus.frame_clk = 1'b1;
            @(negedge clk);
            bus.frame_clk = 1'b0;
            repeat (2) @(negedge clk);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_x"},     32'(bus.snakeX_pos), 320);
        check_eq({tag, "_y"},     32'(bus.snakeY_pos), 240);
        check_eq({tag, "_dir"},   32'(bus.motionFlag), 0);
        check_eq({tag, "_state"}, 32'(bus.game_state), 0);
        check_eq({tag, "_dead"},  32'(bus.dead), 0);
        check_eq({tag, "_pulse"}, 32'(bus.step_pulse), 0);
    endtask

    // Scoreboard side: every committed step must match the oldest queued expectation
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.step_pulse) begin
                step_exp_t e;
                pulse_cnt++;
                check_eq("pulse_gap", 32'(prev_pulse), 0);
                if (sb_q.size() == 0) begin
                    check_eq("sb_unexpected_step", 32'(sb_q.size()), 1);
                end else begin
                    e = sb_q.pop_front();
                    check_eq("sb_x",   32'(bus.snakeX_pos), 32'(e.x));
                    check_eq("sb_y",   32'(bus.snakeY_pos), 32'(e.y));
                    check_eq("sb_dir", 32'(bus.motionFlag), 32'(e.dir));
                end
            end
            prev_pulse = bus.step_pulse;
        end else begin
            prev_pulse = 1'b0;
        end
    end

    initial begin
        n_checks      = 0;
        n_pass        = 0;
        pulse_cnt     = 0;
        prev_pulse    = 1'b0;
        rst           = 1'b1;
        bus.frame_clk = 1'b0;
        bus.keycode   = 8'h00;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_reset_state("reset");
        check_eq("size", 32'(bus.snake_size), 12);

        // Cadence: start moving right, one step after the 8th tick
        press(8'h07);
        check_eq("idle_to_run", 32'(bus.game_state), 1);
        check_eq("idle_dir",    32'(bus.motionFlag), 3);
        push_exp(344, 240, 3);
        pc = pulse_cnt;
        do_frames(7);
        check_eq("cadence_hold_x", 32'(bus.snakeX_pos), 320);
        bus.frame_clk = 1'b1;
        @(negedge clk);
        bus.frame_clk = 1'b0;
        check_eq("pulse_n1", 32'(bus.step_pulse), 0);
        @(negedge clk);
        check_eq("pulse_n2", 32'(bus.step_pulse), 1);
        @(negedge clk);
        check_eq("pulse_n3", 32'(bus.step_pulse), 0);
        check_eq("cadence_count", 32'(pulse_cnt - pc), 1);

        // Reversal: A rejected while heading D, then W accepted
        press(8'h04);
        press(8'h1A);
        push_exp(344, 216, 0);
        do_frames(8);
        check_eq("rev_dir_up", 32'(bus.motionFlag), 0);
        press(8'h07);
        push_exp(368, 216, 3);
        do_frames(8);
        press(8'h04);
        push_exp(392, 216, 3);
        do_frames(8);
        check_eq("rev_still_right", 32'(bus.snakeX_pos), 392);

        // Reset mid-RUN with a partially advanced frame counter
        do_frames(3);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_reset_state("midrun_reset");

        // Wall: 12 legal steps right, the 13th dies
        press(8'h07);
        for (int i = 1; i <= 12; i++) push_exp(320 + 24 * i, 240, 3);
        pc = pulse_cnt;
        do_frames(96);
        check_eq("wall_x",      32'(bus.snakeX_pos), 608);
        check_eq("wall_pulses", 32'(pulse_cnt - pc), 12);
        pc = pulse_cnt;
        do_frames(8);
        check_eq("dead_flag",    32'(bus.dead), 1);
        check_eq("dead_state",   32'(bus.game_state), 2);
        check_eq("dead_x_hold",  32'(bus.snakeX_pos), 608);
        check_eq("dead_no_step", 32'(pulse_cnt - pc), 0);

        // Restart: direction ignored in DEAD, Enter returns to IDLE at START
        press(8'h1A);
        check_eq("dead_key_state", 32'(bus.game_state), 2);
        check_eq("dead_key_dir",   32'(bus.motionFlag), 3);
        press(8'h28);
        check_reset_state("restart");

        // Same-cycle key and step: S lands during the tick that steps left
        press(8'h04);
        push_exp(296, 240, 1);
        push_exp(296, 264, 2);
        do_frames(7);
        bus.frame_clk = 1'b1;
        @(negedge clk);
        bus.frame_clk = 1'b0;
        bus.keycode   = 8'h16;
        @(negedge clk);
        bus.keycode   = 8'h00;
        repeat (2) @(negedge clk);
        check_eq("same_cycle_left", 32'(bus.snakeX_pos), 296);
        do_frames(8);
        check_eq("same_cycle_down_y", 32'(bus.snakeY_pos), 264);
        check_eq("same_cycle_dir",    32'(bus.motionFlag), 2);

        check_eq("sb_drained", 32'(sb_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
